decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter SEL_W, default 3: select width; output width OUT_W = 2**SEL_W (derived, not overridable).
REQ-002 Parameter DIV, default 4, legal range 1..255: scan prescale, clocks per scan step.
REQ-003 clka  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 E  input  1  enable; low blanks Out and freezes scan.
REQ-006 Mode  input  1  0 = direct decode of In, 1 = auto-scan.
REQ-007 In  input  SEL_W  select in direct mode; scan start index on entering scan.
REQ-008 Out  output  OUT_W  registered one-hot (or all-zero) decode.
REQ-009 Idx  output  SEL_W  currently driven index.
REQ-010 Wrap  output  1  one-cycle pulse on scan index wrap OUT_W-1 -> 0.

Function
REQ-011 States: IDLE (E=0), DIRECT (E=1, Mode=0), SCAN (E=1, Mode=1); next state evaluated every clka edge from E and Mode.
REQ-012 IDLE: Out = 0; Idx, prescaler and Wrap held/cleared (Wrap = 0); Idx keeps its last value.
REQ-013 DIRECT: Out <= 1 << In, Idx <= In; latency exactly one clock from In to Out.
REQ-014 Entry into SCAN from any other state: Idx <= In, prescaler <= 0, Out <= 1 << In on the entry edge.
REQ-015 SCAN: prescaler counts 0..DIV-1; on the edge where it equals DIV-1 it returns to 0 and Idx increments by 1.
REQ-016 Idx increment wraps modulo OUT_W; the edge taking Idx from OUT_W-1 to 0 sets Wrap = 1 for exactly that one cycle.
REQ-017 DIV = 1: Idx advances every clock; Wrap asserts once every OUT_W clocks.
REQ-018 Out in SCAN always equals 1 << Idx (same cycle as Idx), except during blank cycles per REQ-024.
REQ-019 SCAN -> IDLE (E falls): Out = 0 next edge; prescaler and Idx freeze; E rising back with Mode=1 re-enters per REQ-014 (reload from In).
REQ-020 SCAN <-> DIRECT switch takes effect on the next edge; no partial step, prescaler cleared.
REQ-021 Out is never multi-hot in any cycle, including mode/enable transitions.

Reset
REQ-022 While rst high at a clka edge: state = IDLE, Out = 0, Idx = 0, Wrap = 0, prescaler = 0; rst overrides E/Mode.
REQ-023 Reset asserted mid-scan aborts the step; first edge after rst release evaluates REQ-011 normally.

Configuration
REQ-024 Macro DECODER_SCAN_BLANK_EN defined: each SCAN index step inserts one blank cycle (Out = 0, Idx already updated) before Out shows the new one-hot; step period becomes DIV+1 clocks min(DIV,1) visible; Wrap timing tied to Idx update.
REQ-025 Macro undefined: no blank cycle; Out changes directly between adjacent one-hot values, step period = DIV clocks.

Structure
REQ-026 Package decoder_pkg holds: state enum (IDLE, DIRECT, SCAN), mode constants MODE_DIRECT/MODE_SCAN, default SEL_W and DIV.
REQ-027 Prescaler implemented as sub-module tick_gen (param DIV; inputs clka, rst, clr, en; output tick one-cycle pulse).
REQ-028 Decode of index to one-hot is a function in decoder_pkg, shared by DIRECT and SCAN paths.

Verification (SEL_W=3, DIV=4)
REQ-029 rst=1 two cycles, E=1 Mode=1 In=5 -> all outputs 0 during rst; Out=8'h20 first edge after release.
REQ-030 Direct: E=1 Mode=0, In stepped 0..7 every clock -> Out 8'h01..8'h80, each one clock after In; Idx matches.
REQ-031 Scan from In=6: Out 8'h40 for 4 clocks, 8'h80 for 4, then 8'h01 with Wrap=1 exactly one cycle; Wrap period 32 clocks.
REQ-032 E dropped mid-scan at Idx=3 for 5 clocks -> Out=0, Idx stays 3; E raised with In=1 -> Out=8'h02, prescaler restarts.
REQ-033 DIV=1 build: Out rotates each clock, Wrap every 8 clocks; with DECODER_SCAN_BLANK_EN, zero cycle between each step and Out never multi-hot.
REQ-034 rst asserted mid-step (prescaler=2) -> next edge all zero/IDLE; no Wrap glitch.

Source files
------------

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types, constants and one-hot decode for decoder_scan
//   state_t     : IDLE / DIRECT / SCAN operating states
//   MODE_*      : values of the Mode input
//   DEFAULT_*   : default SEL_W and DIV for decoder_scan
//   onehot()    : index (up to 8 bits) to one-hot, MAX_OUT_W wide; callers cast down
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int DEFAULT_SEL_W = 3;
  localparam int DEFAULT_DIV   = 4;

  // Widest decode supported (SEL_W up to 8).
  localparam int MAX_OUT_W = 256;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [7:0] idx);
    logic [MAX_OUT_W-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/decoder_scan_tick_gen.sv
// rtl/decoder_scan_tick_gen.sv - scan prescaler producing one tick every DIV enabled clocks
//   clka : clock            rst : sync active-high reset
//   clr  : restart count    en  : count enable (count frozen when low)
//   tick : high for the enabled cycle in which the count sits at DIV-1
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clka,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [7:0] cnt;

  // Combinational off the registered count so the owner acts on the same edge
  // that wraps the count back to zero.
  assign tick = en && (cnt == 8'(DIV - 1));

  always_ff @(posedge clka) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered one-hot decoder with direct and auto-scan modes
//   clka : clock                       rst  : sync active-high reset
//   E    : enable (low blanks Out, freezes scan)
//   Mode : 0 direct decode of In, 1 auto-scan starting at In
//   In   : SEL_W select / scan start   Out  : OUT_W one-hot or zero
//   Idx  : index currently driven      Wrap : one-cycle pulse on Idx OUT_W-1 -> 0
//   Build option DECODER_SCAN_BLANK_EN: one all-zero Out cycle after every scan step.
//   SEL_W range 1..8, DIV range 1..255.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W = DEFAULT_SEL_W,
  parameter int DIV   = DEFAULT_DIV
) (
  input  logic                  clka,
  input  logic                  rst,
  input  logic                  E,
  input  logic                  Mode,
  input  logic [SEL_W-1:0]      In,
  output logic [2**SEL_W-1:0]   Out,
  output logic [SEL_W-1:0]      Idx,
  output logic                  Wrap
);

  localparam int OUT_W = 2**SEL_W;

  state_t           state;
  logic             scan_hold;
  logic             pre_clr;
  logic             pre_en;
  logic             tick;
  logic [SEL_W-1:0] idx_next;

  // Already scanning and staying in scan on this edge.
  assign scan_hold = E && (Mode == MODE_SCAN) && (state == SCAN);
  // Prescaler restarts on any enabled edge that is not a continuing scan;
  // with E low it neither counts nor clears (frozen).
  assign pre_clr   = E && !scan_hold;
  assign idx_next  = Idx + SEL_W'(1);

`ifdef DECODER_SCAN_BLANK_EN
  logic blank;
  // Prescaler pauses during the blank cycle so a step spans DIV+1 clocks.
  assign pre_en = scan_hold && !blank;
`else
  assign pre_en = scan_hold;
`endif

  tick_gen #(.DIV(DIV)) u_tick (
    .clka (clka),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  always_ff @(posedge clka) begin
    if (rst) begin
      state <= IDLE;
      Out   <= '0;
      Idx   <= '0;
      Wrap  <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
      blank <= 1'b0;
`endif
    end else begin
      Wrap  <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
      blank <= 1'b0;
`endif
      if (!E) begin
        state <= IDLE;
        Out   <= '0;
      end else if (Mode == MODE_DIRECT) begin
        state <= DIRECT;
        Idx   <= In;
        Out   <= OUT_W'(onehot(8'(In)));
      end else if (state != SCAN) begin
        state <= SCAN;
        Idx   <= In;
        Out   <= OUT_W'(onehot(8'(In)));
      end else begin
`ifdef DECODER_SCAN_BLANK_EN
        if (blank) begin
          Out <= OUT_W'(onehot(8'(Idx)));
        end else if (tick) begin
          Idx   <= idx_next;
          Out   <= '0;
          blank <= 1'b1;
          Wrap  <= &Idx;
        end
`else
        if (tick) begin
          Idx  <= idx_next;
          Out  <= OUT_W'(onehot(8'(idx_next)));
          Wrap <= &Idx;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - self-checking bench for decoder_scan (DIV=4 and DIV=1 instances)
module tb_decoder_scan;

  localparam int OUT_W = 8;
`ifdef DECODER_SCAN_BLANK_EN
  localparam int BLANK = 1;
`else
  localparam int BLANK = 0;
`endif

  logic       clka = 1'b0;
  logic       rst  = 1'b1;
  logic       E    = 1'b0;
  logic       Mode = 1'b0;
  logic [2:0] In   = 3'd0;

  logic [7:0] out4, out1;
  logic [2:0] idx4, idx1;
  logic       wrap4, wrap1;

  int checks = 0;
  int errors = 0;

  always #5 clka = ~clka;

  decoder_scan #(.SEL_W(3), .DIV(4)) dut4 (
    .clka(clka), .rst(rst), .E(E), .Mode(Mode), .In(In),
    .Out(out4), .Idx(idx4), .Wrap(wrap4)
  );

  decoder_scan #(.SEL_W(3), .DIV(1)) dut1 (
    .clka(clka), .rst(rst), .E(E), .Mode(Mode), .In(In),
    .Out(out1), .Idx(idx1), .Wrap(wrap1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: scan position derived from cycles since scan entry.
  int m_state[2];
  int m_start[2];
  int m_age[2];
  int m_idx[2];
  int m_out[2];
  int m_wrap[2];
  int m_div[2] = '{4, 1};
  bit started = 1'b0;

  always @(posedge clka) begin
    int p, a, steps, ph;
    for (int d = 0; d < 2; d++) begin
      m_wrap[d] = 0;
      if (rst) begin
        m_state[d] = 0; m_idx[d] = 0; m_out[d] = 0;
      end else if (!E) begin
        m_state[d] = 0; m_out[d] = 0;
      end else if (!Mode) begin
        m_state[d] = 1; m_idx[d] = int'(In); m_out[d] = 1 << In;
      end else begin
        if (m_state[d] != 2) begin
          m_state[d] = 2; m_start[d] = int'(In); m_age[d] = 0;
        end else begin
          m_age[d]++;
        end
        p     = m_div[d] + BLANK;
        a     = m_age[d] + BLANK;
        steps = a / p;
        ph    = a % p;
        m_idx[d]  = (m_start[d] + steps) % OUT_W;
        m_out[d]  = (BLANK == 1 && ph == 0) ? 0 : (1 << m_idx[d]);
        m_wrap[d] = (ph == 0 && steps > 0 && m_idx[d] == 0) ? 1 : 0;
      end
    end
    started = 1'b1;
  end

  always @(negedge clka) begin
    if (started) begin
      check("out_div4",  int'(out4),  m_out[0]);
      check("idx_div4",  int'(idx4),  m_idx[0]);
      check("wrap_div4", int'(wrap4), m_wrap[0]);
      check("onehot_div4", ($countones(out4) <= 1) ? 1 : 0, 1);
      check("out_div1",  int'(out1),  m_out[1]);
      check("idx_div1",  int'(idx1),  m_idx[1]);
      check("wrap_div1", int'(wrap1), m_wrap[1]);
      check("onehot_div1", ($countones(out1) <= 1) ? 1 : 0, 1);
    end
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  int n;

  initial begin
    // Reset held with scan requested
    rst = 1'b1; E = 1'b1; Mode = 1'b1; In = 3'd5;
    tick(); tick();
    check("rst_out", int'(out4), 0);
    check("rst_idx", int'(idx4), 0);
    check("rst_wrap", int'(wrap4), 0);
    rst = 1'b0;
    tick();
    check("rel_out", int'(out4), 'h20);
    check("rel_idx", int'(idx4), 5);
    check("model_rel_out", m_out[0], 'h20);

    // Direct decode
    Mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      In = 3'(i);
      tick();
      check("dir_out", int'(out4), 1 << i);
      check("dir_idx", int'(idx4), i);
    end

    // Scan from 6
    In = 3'd6; Mode = 1'b1;
    tick();
`ifndef DECODER_SCAN_BLANK_EN
    for (int k = 0; k < 4; k++) begin
      check("scan_40", int'(out4), 'h40);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      check("scan_80", int'(out4), 'h80);
      check("scan_80_wrap", int'(wrap4), 0);
      tick();
    end
    check("scan_wrap_out", int'(out4), 'h01);
    check("scan_wrap_pulse", int'(wrap4), 1);
`endif
    n = 0;
    while (!wrap4 && n < 200) begin tick(); n++; end
    check("wrap_seen", int'(wrap4), 1);
    n = 0;
    do begin tick(); n++; end while (!wrap4 && n < 200);
    check("wrap_period_div4", n, 8 * (4 + BLANK));

    // Drop E at Idx=3
    n = 0;
    while (idx4 != 3'd3 && n < 200) begin tick(); n++; end
    check("reach_idx3", int'(idx4), 3);
    E = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("idle_out", int'(out4), 0);
      check("idle_idx", int'(idx4), 3);
    end
    E = 1'b1; In = 3'd1;
    tick();
    check("reenter_out", int'(out4), 'h02);
    check("reenter_idx", int'(idx4), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("reenter_hold", int'(out4), 'h02);
    end
    tick();
    tick();
    tick();

    // Reset mid-step
    rst = 1'b1;
    tick();
    check("midrst_out", int'(out4), 0);
    check("midrst_idx", int'(idx4), 0);
    check("midrst_wrap", int'(wrap4), 0);
    check("midrst_out1", int'(out1), 0);
    rst = 1'b0; In = 3'd7;
    tick();
    check("postrst_out", int'(out4), 'h80);
    check("postrst_idx", int'(idx4), 7);

    // Mode switches
    Mode = 1'b0; In = 3'd2;
    tick();
    check("to_direct", int'(out4), 'h04);
    Mode = 1'b1; In = 3'd3;
    tick();
    check("to_scan", int'(out4), 'h08);
    check("to_scan_idx", int'(idx4), 3);

    // DIV=1 wrap period
    n = 0;
    while (!wrap1 && n < 100) begin tick(); n++; end
    check("wrap1_seen", int'(wrap1), 1);
    n = 0;
    do begin tick(); n++; end while (!wrap1 && n < 100);
    check("wrap_period_div1", n, 8 * (1 + BLANK));

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
